// File: rtl/rv32i_ex_vector_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_ex_vector_seq_if
// Brief    : Control, table-load and stimulus/result bundle of the EX vector
//            sequencer.
// Revision : 1.0
// ============================================================================
interface rv32i_ex_vector_seq_if #(
    parameter int NUM_VEC = 32,
    parameter int DATA_W  = 32
);
    localparam int AW = $clog2(NUM_VEC);

    logic              start;
    logic              step;
    logic              mode;
    logic [AW-1:0]     last_idx;
    logic              ld_we;
    logic [AW-1:0]     ld_addr;
    logic [2:0]        ld_sel;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] result_in;

    logic [DATA_W-1:0] iw_out;
    logic [DATA_W-1:0] rs1_data_out;
    logic [DATA_W-1:0] rs2_data_out;
    logic [DATA_W-1:0] pc_out;
    logic [AW-1:0]     cur_idx;
    logic              busy;
    logic              done;
    logic [AW:0]       pass_cnt;
    logic [AW:0]       fail_cnt;
    logic              fail_seen;
    logic [AW-1:0]     first_fail_idx;
    logic [DATA_W-1:0] first_fail_result;

    modport slave (
        input  start, step, mode, last_idx, ld_we, ld_addr, ld_sel, ld_data, result_in,
        output iw_out, rs1_data_out, rs2_data_out, pc_out, cur_idx, busy, done,
               pass_cnt, fail_cnt, fail_seen, first_fail_idx, first_fail_result
    );

    modport master (
        output start, step, mode, last_idx, ld_we, ld_addr, ld_sel, ld_data, result_in,
        input  iw_out, rs1_data_out, rs2_data_out, pc_out, cur_idx, busy, done,
               pass_cnt, fail_cnt, fail_seen, first_fail_idx, first_fail_result
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_ex_vector_seq.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_ex_vector_seq
// Brief    : Plays a loadable table of vectors into the rv32i EX stage and
//            scores each result against its expected value.
// Revision : 1.0
// ============================================================================
module rv32i_ex_vector_seq #(
    parameter int NUM_VEC    = 32,
    parameter int DATA_W     = 32,
    parameter int EX_LATENCY = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    rv32i_ex_vector_seq_if.slave bus
);
    localparam int         AW          = $clog2(NUM_VEC);
    localparam logic [3:0] c_wait_last = (EX_LATENCY > 0) ? 4'(EX_LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    logic [DATA_W-1:0] tbl_iw  [NUM_VEC];
    logic [DATA_W-1:0] tbl_rs1 [NUM_VEC];
    logic [DATA_W-1:0] tbl_rs2 [NUM_VEC];
    logic [DATA_W-1:0] tbl_pc  [NUM_VEC];
    logic [DATA_W-1:0] tbl_exp [NUM_VEC];
    logic [NUM_VEC-1:0] tbl_chk;

    state_t            state_q, state_d;
    logic [AW-1:0]     cur_idx_q, cur_idx_d;
    logic [AW-1:0]     last_idx_q, last_idx_d;
    logic              mode_q, mode_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] iw_q, iw_d, rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              chk_q, chk_d;
    logic [AW:0]       pass_q, pass_d, fail_q, fail_d;
    logic              fail_seen_q, fail_seen_d;
    logic [AW-1:0]     ffi_q, ffi_d;
    logic [DATA_W-1:0] ffr_q, ffr_d;
    logic              w_busy;

    assign w_busy = (state_q != S_IDLE) && (state_q != S_DONE);

    // Table has no reset: contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (bus.ld_we && !w_busy) begin
            case (bus.ld_sel)
                3'd0:    tbl_iw[bus.ld_addr]  <= bus.ld_data;
                3'd1:    tbl_rs1[bus.ld_addr] <= bus.ld_data;
                3'd2:    tbl_rs2[bus.ld_addr] <= bus.ld_data;
                3'd3:    tbl_pc[bus.ld_addr]  <= bus.ld_data;
                3'd4:    tbl_exp[bus.ld_addr] <= bus.ld_data;
                3'd5:    tbl_chk[bus.ld_addr] <= bus.ld_data[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_idx_q   <= '0;
            last_idx_q  <= '0;
            mode_q      <= 1'b0;
            wait_cnt_q  <= '0;
            iw_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            pc_q        <= '0;
            exp_q       <= '0;
            chk_q       <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
            fail_seen_q <= 1'b0;
            ffi_q       <= '0;
            ffr_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            last_idx_q  <= last_idx_d;
            mode_q      <= mode_d;
            wait_cnt_q  <= wait_cnt_d;
            iw_q        <= iw_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            pc_q        <= pc_d;
            exp_q       <= exp_d;
            chk_q       <= chk_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_seen_q <= fail_seen_d;
            ffi_q       <= ffi_d;
            ffr_q       <= ffr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        last_idx_d  = last_idx_q;
        mode_d      = mode_q;
        wait_cnt_d  = wait_cnt_q;
        iw_d        = iw_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        pc_d        = pc_q;
        exp_d       = exp_q;
        chk_d       = chk_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_seen_d = fail_seen_q;
        ffi_d       = ffi_q;
        ffr_d       = ffr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    pass_d      = '0;
                    fail_d      = '0;
                    fail_seen_d = 1'b0;
                    ffi_d       = '0;
                    ffr_d       = '0;
                    cur_idx_d   = '0;
                    mode_d      = bus.mode;
                    // An AW-bit index can never exceed NUM_VEC-1, so latching is the clamp.
                    last_idx_d  = bus.last_idx;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                iw_d       = tbl_iw[cur_idx_q];
                rs1_d      = tbl_rs1[cur_idx_q];
                rs2_d      = tbl_rs2[cur_idx_q];
                pc_d       = tbl_pc[cur_idx_q];
                exp_d      = tbl_exp[cur_idx_q];
                chk_d      = tbl_chk[cur_idx_q];
                wait_cnt_d = '0;
                state_d    = (EX_LATENCY == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == c_wait_last) begin
                    state_d = S_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (chk_q) begin
                    if (bus.result_in == exp_q) begin
                        pass_d = pass_q + 1'b1;
                    end else begin
                        fail_d = fail_q + 1'b1;
                        if (!fail_seen_q) begin
                            fail_seen_d = 1'b1;
                            ffi_d       = cur_idx_q;
                            ffr_d       = bus.result_in;
                        end
                    end
                end
                if (cur_idx_q == last_idx_q) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_PAUSE;
                end else begin
                    cur_idx_d = cur_idx_q + 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_PAUSE: begin
                if (bus.step) begin
                    cur_idx_d = cur_idx_q + 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.iw_out            = iw_q;
    assign bus.rs1_data_out      = rs1_q;
    assign bus.rs2_data_out      = rs2_q;
    assign bus.pc_out            = pc_q;
    assign bus.cur_idx           = cur_idx_q;
    assign bus.busy              = w_busy;
    assign bus.done              = (state_q == S_DONE);
    assign bus.pass_cnt          = pass_q;
    assign bus.fail_cnt          = fail_q;
    assign bus.fail_seen         = fail_seen_q;
    assign bus.first_fail_idx    = ffi_q;
    assign bus.first_fail_result = ffr_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_ex_vector_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_ex_vector_seq
// Brief    : Directed bench for the EX vector sequencer, latency 1 and 0.
// Revision : 1.0
// ============================================================================
module tb_rv32i_ex_vector_seq;
    localparam int NV = 32;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start1, start0, step, mode, ld_we;
    logic [AW-1:0] last_idx, ld_addr;
    logic [2:0]    ld_sel;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] res1_q;
    int            n_chk = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    rv32i_ex_vector_seq_if #(.NUM_VEC(NV), .DATA_W(DW)) bus1 ();
    rv32i_ex_vector_seq_if #(.NUM_VEC(NV), .DATA_W(DW)) bus0 ();

    rv32i_ex_vector_seq #(.NUM_VEC(NV), .DATA_W(DW), .EX_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    rv32i_ex_vector_seq #(.NUM_VEC(NV), .DATA_W(DW), .EX_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));

    function automatic logic [31:0] alu(input logic [31:0] iw, input logic [31:0] a,
                                        input logic [31:0] b);
        case (iw[14:12])
            3'b000:  return iw[30] ? a - b : a + b;
            3'b100:  return a ^ b;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return a + b;
        endcase
    endfunction

    // Ideal EX stage: one register stage for dut1, purely combinational for dut0.
    always @(posedge clk) res1_q <= alu(bus1.iw_out, bus1.rs1_data_out, bus1.rs2_data_out);
    assign bus1.result_in = res1_q;
    assign bus0.result_in = alu(bus0.iw_out, bus0.rs1_data_out, bus0.rs2_data_out);

    assign bus1.start = start1;   assign bus0.start = start0;
    assign bus1.step = step;      assign bus0.step = step;
    assign bus1.mode = mode;      assign bus0.mode = mode;
    assign bus1.last_idx = last_idx; assign bus0.last_idx = last_idx;
    assign bus1.ld_we = ld_we;    assign bus0.ld_we = ld_we;
    assign bus1.ld_addr = ld_addr; assign bus0.ld_addr = ld_addr;
    assign bus1.ld_sel = ld_sel;  assign bus0.ld_sel = ld_sel;
    assign bus1.ld_data = ld_data; assign bus0.ld_data = ld_data;

    task automatic ld(input logic [AW-1:0] a, input logic [2:0] s, input logic [DW-1:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_sel = s; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic load_vec(input logic [AW-1:0] a, input logic [31:0] iw, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] exp, input logic chk);
        ld(a, 3'd0, iw);
        ld(a, 3'd1, r1);
        ld(a, 3'd2, r2);
        ld(a, 3'd3, 32'(a) * 4);
        ld(a, 3'd4, exp);
        ld(a, 3'd5, {31'd0, chk});
    endtask

    task automatic load_base();
        load_vec(5'd0, 32'h0000_0033, 32'h0200_0000, 32'h3000_0000, 32'h3200_0000, 1'b1);
        load_vec(5'd1, 32'h4000_0033, 32'd3, 32'd2, 32'd1, 1'b1);
        load_vec(5'd2, 32'h0000_6033, 32'd3, 32'd2, 32'd3, 1'b1);
    endtask

    // Pulses start on dut1 and counts edges until done; busy/done after the first edge are returned.
    task automatic run1(output int cyc, output logic busy_at1, output logic done_at1);
        @(negedge clk);
        start1 = 1'b1; cyc = 0; busy_at1 = 1'b0; done_at1 = 1'b1;
        do begin
            @(negedge clk);
            start1 = 1'b0;
            cyc++;
            if (cyc == 1) begin busy_at1 = bus1.busy; done_at1 = bus1.done; end
        end while (!bus1.done && cyc < 400);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({bus1.busy, bus1.done, bus1.fail_seen} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b, expected 000", {bus1.busy, bus1.done, bus1.fail_seen});
        end
        n_chk++;
        if ({bus1.iw_out, bus1.rs1_data_out, bus1.rs2_data_out, bus1.pc_out, bus1.cur_idx} !== '0) begin
            n_fail++; $display("FAIL reset_stim: got iw=%h cur_idx=%0d, expected zeros", bus1.iw_out, bus1.cur_idx);
        end
        n_chk++;
        if ({bus1.pass_cnt, bus1.fail_cnt, bus1.first_fail_idx, bus1.first_fail_result} !== '0) begin
            n_fail++; $display("FAIL reset_stats: got pass=%0d fail=%0d, expected zeros", bus1.pass_cnt, bus1.fail_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        int cyc; logic b1, d1;
        load_base();
        mode = 1'b0; last_idx = 5'd2;
        run1(cyc, b1, d1);
        n_chk++;
        if (cyc !== 10) begin n_fail++; $display("FAIL free_run_latency: got %0d cycles, expected 10", cyc); end
        n_chk++;
        if (b1 !== 1'b1) begin n_fail++; $display("FAIL free_run_busy_rise: got %b, expected 1", b1); end
        n_chk++;
        if (bus1.pass_cnt !== 6'd3 || bus1.fail_cnt !== 6'd0 || bus1.fail_seen !== 1'b0) begin
            n_fail++; $display("FAIL free_run_stats: got pass=%0d fail=%0d seen=%b, expected 3 0 0",
                               bus1.pass_cnt, bus1.fail_cnt, bus1.fail_seen);
        end
        n_chk++;
        if (bus1.busy !== 1'b0 || bus1.cur_idx !== 5'd2 || bus1.iw_out !== 32'h0000_6033 || bus1.pc_out !== 32'd8) begin
            n_fail++; $display("FAIL free_run_end: got busy=%b idx=%0d iw=%h pc=%h, expected 0 2 00006033 8",
                               bus1.busy, bus1.cur_idx, bus1.iw_out, bus1.pc_out);
        end
    endtask

    task automatic test_fail_capture();
        int cyc; logic b1, d1;
        ld(5'd1, 3'd4, 32'd5);
        run1(cyc, b1, d1);
        n_chk++;
        if (d1 !== 1'b0 || cyc !== 10) begin
            n_fail++; $display("FAIL fail_run_timing: got done_at1=%b cycles=%0d, expected 0 10", d1, cyc);
        end
        n_chk++;
        if (bus1.pass_cnt !== 6'd2 || bus1.fail_cnt !== 6'd1 || bus1.fail_seen !== 1'b1) begin
            n_fail++; $display("FAIL fail_stats: got pass=%0d fail=%0d seen=%b, expected 2 1 1",
                               bus1.pass_cnt, bus1.fail_cnt, bus1.fail_seen);
        end
        n_chk++;
        if (bus1.first_fail_idx !== 5'd1 || bus1.first_fail_result !== 32'd1) begin
            n_fail++; $display("FAIL first_fail: got idx=%0d res=%h, expected 1 1",
                               bus1.first_fail_idx, bus1.first_fail_result);
        end
        ld(5'd1, 3'd4, 32'd1);
    endtask

    task automatic test_chk_disable();
        int cyc; logic b1, d1;
        ld(5'd2, 3'd4, 32'h0000_0BAD);
        ld(5'd2, 3'd5, 32'd0);
        run1(cyc, b1, d1);
        n_chk++;
        if (cyc !== 10 || bus1.pass_cnt !== 6'd2 || bus1.fail_cnt !== 6'd0) begin
            n_fail++; $display("FAIL chk_disable: got cycles=%0d pass=%0d fail=%0d, expected 10 2 0",
                               cyc, bus1.pass_cnt, bus1.fail_cnt);
        end
        ld(5'd2, 3'd4, 32'd3);
        ld(5'd2, 3'd5, 32'd1);
    endtask

    task automatic test_single_step();
        mode = 1'b1; last_idx = 5'd2;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (7) @(negedge clk);
        n_chk++;
        if (bus1.cur_idx !== 5'd0 || bus1.busy !== 1'b1 || bus1.done !== 1'b0 || bus1.pass_cnt !== 6'd1) begin
            n_fail++; $display("FAIL step_pause0: got idx=%0d busy=%b done=%b pass=%0d, expected 0 1 0 1",
                               bus1.cur_idx, bus1.busy, bus1.done, bus1.pass_cnt);
        end
        // Step held over two edges: the second one lands in ISSUE and must be ignored.
        step = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        repeat (6) @(negedge clk);
        n_chk++;
        if (bus1.cur_idx !== 5'd1 || bus1.done !== 1'b0 || bus1.pass_cnt !== 6'd2) begin
            n_fail++; $display("FAIL step_pause1: got idx=%0d done=%b pass=%0d, expected 1 0 2",
                               bus1.cur_idx, bus1.done, bus1.pass_cnt);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++;
        if (bus1.done !== 1'b1 || bus1.cur_idx !== 5'd2 || bus1.pass_cnt !== 6'd3) begin
            n_fail++; $display("FAIL step_done: got done=%b idx=%0d pass=%0d, expected 1 2 3",
                               bus1.done, bus1.cur_idx, bus1.pass_cnt);
        end
        mode = 1'b0;
    endtask

    task automatic test_mid_reset();
        int cyc; logic b1, d1;
        @(negedge clk); start1 = 1'b1;
        repeat (5) begin @(negedge clk); start1 = 1'b0; end
        n_chk++;
        if (bus1.pass_cnt !== 6'd1 || bus1.cur_idx !== 5'd1) begin
            n_fail++; $display("FAIL pre_reset: got pass=%0d idx=%0d, expected 1 1", bus1.pass_cnt, bus1.cur_idx);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_chk++;
        if ({bus1.busy, bus1.done, bus1.pass_cnt, bus1.cur_idx, bus1.iw_out, bus1.rs1_data_out} !== '0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b pass=%0d idx=%0d iw=%h, expected zeros",
                               bus1.busy, bus1.pass_cnt, bus1.cur_idx, bus1.iw_out);
        end
        run1(cyc, b1, d1);
        n_chk++;
        if (cyc !== 10 || bus1.pass_cnt !== 6'd3 || bus1.fail_cnt !== 6'd0) begin
            n_fail++; $display("FAIL restart: got cycles=%0d pass=%0d fail=%0d, expected 10 3 0",
                               cyc, bus1.pass_cnt, bus1.fail_cnt);
        end
    endtask

    task automatic test_busy_guards();
        int cyc;
        @(negedge clk); start1 = 1'b1; cyc = 0;
        do begin
            @(negedge clk);
            start1 = (cyc == 3);
            ld_we = (cyc == 1); ld_addr = 5'd2; ld_sel = 3'd4; ld_data = 32'h999;
            cyc++;
        end while (!bus1.done && cyc < 400);
        ld_we = 1'b0; start1 = 1'b0;
        n_chk++;
        if (cyc !== 10 || bus1.pass_cnt !== 6'd3 || bus1.fail_cnt !== 6'd0) begin
            n_fail++; $display("FAIL busy_guards: got cycles=%0d pass=%0d fail=%0d, expected 10 3 0",
                               cyc, bus1.pass_cnt, bus1.fail_cnt);
        end
    endtask

    task automatic test_ld_with_start();
        int cyc;
        @(negedge clk);
        start1 = 1'b1; ld_we = 1'b1; ld_addr = 5'd2; ld_sel = 3'd4; ld_data = 32'h777; cyc = 0;
        do begin @(negedge clk); start1 = 1'b0; ld_we = 1'b0; cyc++; end
        while (!bus1.done && cyc < 400);
        n_chk++;
        if (cyc !== 10 || bus1.fail_cnt !== 6'd1 || bus1.first_fail_idx !== 5'd2 || bus1.first_fail_result !== 32'd3) begin
            n_fail++; $display("FAIL ld_with_start: got cycles=%0d fail=%0d idx=%0d res=%h, expected 10 1 2 3",
                               cyc, bus1.fail_cnt, bus1.first_fail_idx, bus1.first_fail_result);
        end
        ld(5'd2, 3'd4, 32'd3);
    endtask

    task automatic test_reset_beats_start();
        @(negedge clk); reset = 1'b1; start1 = 1'b1;
        @(negedge clk); reset = 1'b0; start1 = 1'b0;
        n_chk++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_vs_start: got busy=%b done=%b, expected 0 0", bus1.busy, bus1.done);
        end
    endtask

    task automatic test_clamp();
        int cyc; logic b1, d1;
        logic [7:0] big;
        for (int i = 3; i < NV; i++) begin
            load_vec(5'(i), 32'h0000_0033, 32'(i), 32'(2 * i), 32'(3 * i), 1'b1);
        end
        big = 8'hFF;
        last_idx = big[AW-1:0];
        run1(cyc, b1, d1);
        n_chk++;
        if (cyc !== 97 || bus1.pass_cnt !== 6'd32 || bus1.fail_cnt !== 6'd0 || bus1.cur_idx !== 5'd31) begin
            n_fail++; $display("FAIL clamp_run: got cycles=%0d pass=%0d fail=%0d idx=%0d, expected 97 32 0 31",
                               cyc, bus1.pass_cnt, bus1.fail_cnt, bus1.cur_idx);
        end
    endtask

    task automatic test_latency0();
        int cyc;
        load_base();
        mode = 1'b0; last_idx = 5'd2;
        @(negedge clk); start0 = 1'b1; cyc = 0;
        do begin @(negedge clk); start0 = 1'b0; cyc++; end
        while (!bus0.done && cyc < 400);
        n_chk++;
        if (cyc !== 7 || bus0.pass_cnt !== 6'd3 || bus0.fail_cnt !== 6'd0) begin
            n_fail++; $display("FAIL latency0: got cycles=%0d pass=%0d fail=%0d, expected 7 3 0",
                               cyc, bus0.pass_cnt, bus0.fail_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start0 = 1'b0; step = 1'b0; mode = 1'b0;
        last_idx = '0; ld_we = 1'b0; ld_addr = '0; ld_sel = '0; ld_data = '0;
        test_reset();
        test_free_run();
        test_fail_capture();
        test_chk_disable();
        test_single_step();
        test_mid_reset();
        test_busy_guards();
        test_ld_with_start();
        test_reset_beats_start();
        test_clamp();
        test_latency0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rv32i_ex_vector_seq.md
# rv32i_ex_vector_seq

Self-checking stimulus sequencer for the rv32i execute stage. It holds a loadable table of instruction and operand vectors and plays them into the EX stage one at a time, in free-run or single-step mode. It compares each EX result against an expected value and keeps pass/fail statistics. It replaces static switch-selected stimulus with a parametrised, sequential, on-board regression engine that sits between board I/O and rv32i_exTop.

## Interface
- NUM_VEC, 32: vector table depth; power of two, 2..256; AW = $clog2(NUM_VEC).
- DATA_W, 32: width of iw/rs1/rs2/pc/expected/result fields.
- EX_LATENCY, 1: cycles from vector presentation to valid result_in; range 0..15.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a run from index 0.
- step  in  1  one-cycle pulse; advances one vector in single-step mode.
- mode  in  1  0 = free-run, 1 = single-step; sampled on start.
- last_idx  in  AW  index of final vector in the run.
- ld_we  in  1  table write enable.
- ld_addr  in  AW  table write index.
- ld_sel  in  3  field select: 0 iw, 1 rs1, 2 rs2, 3 pc, 4 expected, 5 chk_en (bit 0 of ld_data).
- ld_data  in  DATA_W  table write data.
- result_in  in  DATA_W  EX-stage result (ALU/rd output).
- iw_out, rs1_data_out, rs2_data_out, pc_out  out  DATA_W  stimulus to the EX stage.
- cur_idx  out  AW  index of the vector currently presented.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or reset.
- pass_cnt, fail_cnt  out  AW+1  checked-vector tallies.
- fail_seen  out  1  at least one mismatch this run.
- first_fail_idx  out  AW  index of the first mismatch.
- first_fail_result  out  DATA_W  result_in captured at the first mismatch.

## Operation
- Table entry = {iw, rs1, rs2, pc, expected, chk_en}. The table is not cleared by reset. Contents are undefined until written.
- Write rule: ld_we writes field ld_sel at ld_addr.
  - The write is ignored while busy=1.
  - ld_sel values 6 and 7 are ignored.
- FSM states: IDLE, ISSUE, WAIT, CHECK, PAUSE, DONE.
- IDLE/DONE, on start:
  - Clear the counters, fail_seen, first_fail_idx and first_fail_result.
  - Set cur_idx=0, latch mode, set busy=1, go to ISSUE.
- ISSUE: register the table entry at cur_idx onto the stimulus outputs, then go to WAIT, or straight to CHECK when EX_LATENCY=0.
- WAIT: count EX_LATENCY cycles, then go to CHECK.
- CHECK: sample result_in.
  - chk_en=1 and result_in==expected: pass_cnt+1.
  - chk_en=1 and mismatch: fail_cnt+1. If fail_seen=0, set fail_seen and capture first_fail_idx and first_fail_result.
  - chk_en=0: no counter change.
- After CHECK:
  - cur_idx==last_idx: go to DONE (busy=0, done=1).
  - Otherwise in free-run: cur_idx+1, go to ISSUE.
  - Otherwise in single-step: go to PAUSE.
- PAUSE: on step, cur_idx+1 and go to ISSUE.
- start while busy is ignored. step outside PAUSE is ignored.
- last_idx is latched on start. A value of NUM_VEC-1 or more is clamped to NUM_VEC-1.
- Counters are AW+1 bits, so they cannot overflow within one run.

## Timing
- Reset values:
  - Stimulus outputs 0; cur_idx 0.
  - busy 0, done 0; counters 0.
  - fail_seen 0, first_fail_idx 0, first_fail_result 0.
  - FSM in IDLE.
- start in cycle T: busy=1 at T+1 (ISSUE). Stimulus is valid at T+2 and held stable through CHECK.
- Per-vector period in free-run is EX_LATENCY+2 cycles. A full run of N vectors sets done at T+1+N·(EX_LATENCY+2).
- CHECK samples result_in exactly EX_LATENCY cycles after the stimulus becomes valid.
- Counters and fail capture update on the clock edge that leaves CHECK.
- Single-step: step in cycle S, while in PAUSE, puts the FSM in ISSUE at S+1.
- done falls on the cycle after start; busy rises on the same cycle.
- Reset asserted mid-run: on the next edge the FSM returns to IDLE and all outputs take their reset values. The table is preserved.
- Simultaneous start and reset: reset wins. Simultaneous ld_we and start from IDLE: the write lands and start is honoured. The written entry is used if it is reached later in the run.

## Test plan
- Load 3 vectors: ADD (iw 0x00000033, rs1 0x02000000, rs2 0x30000000, exp 0x32000000), SUB (0x40000033, 3, 2, exp 1), OR (0x00006033, 3, 2, exp 3). Set last_idx=2, free-run, EX_LATENCY=1, model DUT ideal, start → done exactly 10 cycles after start; pass_cnt=3, fail_cnt=0, fail_seen=0.
- Same table with vector 1 expected set to 5 → fail_cnt=1, first_fail_idx=1, first_fail_result=1, pass_cnt=2.
- Vector 2 with chk_en=0 and a wrong expected value → pass_cnt=2, fail_cnt=0; done still asserts.
- Single-step mode → FSM stalls in PAUSE after each CHECK; cur_idx advances only on step pulses; step while in ISSUE is ignored; done after 2 steps.
- Reset asserted during WAIT of vector 1 → next cycle FSM in IDLE, all outputs 0. A restart reproduces the first scenario's results.
- Edge cases:
  - last_idx=0xFF with NUM_VEC=32: clamped, 32 vectors run.
  - ld_we while busy: table unchanged.
  - start during a run: ignored.
  - Run with EX_LATENCY=0: 2-cycle period.
